memory_stage_mc: RTL

Multicycle, parametrised successor to the single-cycle memory stage: it sits between execute and writeback and holds the same control-word/data-word pipeline registers. Data memory is reached over a valid/ready request channel with a separate response strobe, so memory may take any number of cycles. The stage stalls the pipeline while an access is in flight, performs byte-lane alignment with sign/zero extension for width_p of 32 or 64, and flags misaligned accesses without issuing them.

---
 rtl/memory_stage_mc.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/memory_stage_mc.sv
// Multicycle memory stage: pipeline registers between execute and writeback, with a
// valid/ready data-memory request channel, byte-lane alignment and misalignment detection.
package rvga_pkg;
  typedef struct packed {
    logic [2:0] funct3;
    logic       dmem_r_v;
    logic       dmem_w_v;
    logic       br_v;
    logic       jmp_v;
    logic       rf_w_v;
    logic [4:0] rd_addr;
  } rvga_cword;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] alu_result;
  } rvga_dword;
endpackage

module memory_stage_mc
  import rvga_pkg::*;
#(
  parameter int unsigned width_p = 32,
  localparam int unsigned bytes_p = width_p / 8,
  localparam int unsigned off_w = $clog2(bytes_p)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_v_i,
  input  rvga_cword          cword_i,
  output rvga_cword          cword_o,
  input  rvga_dword          dword_i,
  output rvga_dword          dword_o,
  input  logic [width_p-1:0] alu_result_i,
  input  logic               bru_result_i,
  input  logic [width_p-1:0] st_data_i,
  output logic               dmem_req_v_o,
  input  logic               dmem_req_ready_i,
  output logic               dmem_we_o,
  output logic [width_p-1:0] dmem_addr_o,
  output logic [width_p-1:0] dmem_wdata_o,
  output logic [bytes_p-1:0] dmem_wmask_o,
  input  logic               dmem_resp_v_i,
  input  logic [width_p-1:0] dmem_rdata_i,
  output logic [width_p-1:0] alu_or_ld_result_o,
  output logic               btaken_o,
  output logic               br_v_o,
  output logic               mem_stall_o,
  output logic               misaligned_o
);

  typedef logic [width_p-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e    state, state_next;
  rvga_cword cword_r;
  rvga_dword dword_r, dword_cap;
  word_t     st_data_r;
  logic      bru_r;
  word_t     ld_r;

  logic               cap;
  logic               issue_in;
  logic               req;
  logic               store_r;
  word_t              addr_r;
  logic [off_w-1:0]   off;
  logic [1:0]         size;
  logic [7:0]         size_mask;
  word_t              shifted;
  word_t              load_ext;

  // Size 11 (double) has no legal encoding on a 32-bit datapath.
  function automatic logic misaligned_f(input logic [1:0] sz, input logic [2:0] a);
    logic m;
    m = 1'b0;
    unique case (sz)
      2'b00: m = 1'b0;
      2'b01: m = a[0];
      2'b10: m = (a[1:0] != 2'b00);
      2'b11: m = (width_p == 32) || (a != 3'b000);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  assign cap      = ~stall_v_i & ~mem_stall_o;
  assign issue_in = (cword_i.dmem_r_v | cword_i.dmem_w_v) &
                    ~misaligned_f(cword_i.funct3[1:0], alu_result_i[2:0]);

  always_comb begin
    dword_cap            = dword_i;
    dword_cap.alu_result = 64'(alu_result_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= StIdle;
      cword_r   <= '0;
      dword_r   <= '0;
      st_data_r <= '0;
      bru_r     <= 1'b0;
      ld_r      <= '0;
    end else begin
      state <= state_next;
      if (cap) begin
        cword_r   <= cword_i;
        dword_r   <= dword_cap;
        st_data_r <= st_data_i;
        bru_r     <= bru_result_i;
      end
      if (state == StResp && dmem_resp_v_i) begin
        ld_r <= dmem_rdata_i;
      end
    end
  end

  always_comb begin
    state_next = state;
    if (cap) begin
      state_next = issue_in ? StReq : StIdle;
    end else begin
      unique case (state)
        StReq:   if (dmem_req_ready_i) state_next = StResp;
        StResp:  if (dmem_resp_v_i) state_next = StDone;
        default: state_next = state;
      endcase
    end
  end

  assign addr_r       = dword_r.alu_result[width_p-1:0];
  assign off          = addr_r[off_w-1:0];
  assign size         = cword_r.funct3[1:0];
  assign req          = (state == StReq);
  assign store_r      = cword_r.dmem_w_v;
  assign mem_stall_o  = (state == StReq) || (state == StResp);
  assign misaligned_o = (cword_r.dmem_r_v | cword_r.dmem_w_v) & misaligned_f(size, addr_r[2:0]);

  always_comb begin
    size_mask = 8'h01;
    unique case (size)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      2'b11:   size_mask = 8'hFF;
      default: size_mask = 8'h01;
    endcase
  end

  // Request fields are driven only while requesting so idle outputs read as zero.
  assign dmem_req_v_o = req;
  assign dmem_we_o    = req & store_r;
  assign dmem_addr_o  = req ? (addr_r & ~word_t'(bytes_p - 1)) : '0;
  assign dmem_wdata_o = (req & store_r) ? (st_data_r << {off, 3'b000}) : '0;
  assign dmem_wmask_o = (req & store_r) ? (size_mask[bytes_p-1:0] << off) : '0;

  assign shifted = ld_r >> {off, 3'b000};

  always_comb begin
    load_ext = shifted;
    unique case (size)
      2'b00: load_ext = cword_r.funct3[2] ? word_t'(shifted[7:0])
                                          : word_t'($signed(shifted[7:0]));
      2'b01: load_ext = cword_r.funct3[2] ? word_t'(shifted[15:0])
                                          : word_t'($signed(shifted[15:0]));
      2'b10: load_ext = cword_r.funct3[2] ? word_t'(shifted[31:0])
                                          : word_t'($signed(shifted[31:0]));
      default: load_ext = shifted;
    endcase
  end

  assign alu_or_ld_result_o = misaligned_o     ? '0 :
                              cword_r.dmem_r_v ? load_ext : addr_r;

  assign btaken_o = cword_r.jmp_v | (cword_r.br_v & bru_r);
  assign br_v_o   = cword_r.jmp_v | cword_r.br_v;
  assign cword_o  = cword_r;
  assign dword_o  = dword_r;

endmodule
